pc_unit: RTL and testbench



---
 rtl/pc_unit.sv | 138 +++++++++++++
 tb/tb_pc_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit: program-counter unit for the rv32im core.
//
// Produces the fetch address. It supports sequential advance, branch/jump redirect,
// trap entry, stall, and halt/resume. A redirect whose target is misaligned parks the
// unit in FAULT until a trap is taken. The unit also counts every curr_addr update
// for debug.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous, active-high reset
//   stall          hold curr_addr this cycle (RUN only)
//   redirect_valid load redirect_addr (branch or jump taken)
//   redirect_addr  redirect target
//   trap_valid     load TRAP_VECTOR
//   halt_req       request halt (RUN only)
//   resume         leave HALT
//   curr_addr      registered fetch address
//   pc_valid       curr_addr is a fetch request this cycle (state RUN)
//   misaligned     high while in FAULT
//   fault_addr     offending redirect target, latched on fault entry
//   update_count   number of curr_addr loads/advances since reset
//   state_o        FSM state: BOOT=0, RUN=1, HALT=2, FAULT=3
module pc_unit #(
    parameter int unsigned           XLEN         = 32,
    parameter logic [XLEN-1:0]       RESET_VECTOR = '0,
    parameter logic [XLEN-1:0]       TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int unsigned           INC          = 4,
    parameter int unsigned           ALIGN        = 4,
    parameter int unsigned           COUNT_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_addr,
    input  logic               trap_valid,
    input  logic               halt_req,
    input  logic               resume,
    output logic [XLEN-1:0]    curr_addr,
    output logic               pc_valid,
    output logic               misaligned,
    output logic [XLEN-1:0]    fault_addr,
    output logic [COUNT_W-1:0] update_count,
    output logic [1:0]         state_o
);

    typedef enum logic [1:0] {
        StBoot  = 2'd0,
        StRun   = 2'd1,
        StHalt  = 2'd2,
        StFault = 2'd3
    } state_e;

    localparam logic [XLEN-1:0] IncStep = XLEN'(INC);

    state_e             state_q, state_d;
    logic [XLEN-1:0]    addr_q, addr_d;
    logic [XLEN-1:0]    fault_q, fault_d;
    logic [COUNT_W-1:0] count_q;
    logic               load;
    logic               target_aligned;

    // ALIGN=2 only needs bit 0 clear; anything else is treated as word alignment.
    assign target_aligned = (ALIGN == 2) ? ~redirect_addr[0] : (redirect_addr[1:0] == 2'b00);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        fault_d = fault_q;
        load    = 1'b0;
        unique case (state_q)
            StBoot: begin
                state_d = StRun;
            end
            StRun: begin
                if (trap_valid) begin
                    addr_d = TRAP_VECTOR;
                    load   = 1'b1;
                end else if (redirect_valid) begin
                    if (target_aligned) begin
                        addr_d = redirect_addr;
                        load   = 1'b1;
                    end else begin
                        fault_d = redirect_addr;
                        state_d = StFault;
                    end
                end else if (halt_req) begin
                    state_d = StHalt;
                end else if (!stall) begin
                    addr_d = addr_q + IncStep;
                    load   = 1'b1;
                end
            end
            StHalt: begin
                if (trap_valid) begin
                    addr_d  = TRAP_VECTOR;
                    load    = 1'b1;
                    state_d = StRun;
                end else if (resume) begin
                    // Held address is refetched, so no load.
                    state_d = StRun;
                end
            end
            StFault: begin
                // fault_addr is kept after the trap until the next fault.
                if (trap_valid) begin
                    addr_d  = TRAP_VECTOR;
                    load    = 1'b1;
                    state_d = StRun;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StBoot;
            addr_q  <= RESET_VECTOR;
            fault_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            fault_q <= fault_d;
            if (load) begin
                count_q <= count_q + COUNT_W'(1);
            end
        end
    end

    assign curr_addr    = addr_q;
    assign fault_addr   = fault_q;
    assign update_count = count_q;
    assign state_o      = state_q;
    assign pc_valid     = (state_q == StRun);
    assign misaligned   = (state_q == StFault);

endmodule

// File: tb/tb_pc_unit.sv
// Testbench for pc_unit. Two instances share the same stimulus: one is built with
// ALIGN=4 and the other with ALIGN=2. A behavioural model of each instance is
// checked against its DUT on every cycle after the first reset. Directed
// sequences with literal expectations come first, then a randomized phase.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic        trap_valid = 1'b0;
    logic        halt_req = 1'b0;
    logic        resume = 1'b0;

    logic [31:0] curr_addr   [2];
    logic        pc_valid    [2];
    logic        misaligned  [2];
    logic [31:0] fault_addr  [2];
    logic [31:0] update_count[2];
    logic [1:0]  state_o     [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pc_unit u_dut_a4 (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .trap_valid     (trap_valid),
        .halt_req       (halt_req),
        .resume         (resume),
        .curr_addr      (curr_addr[0]),
        .pc_valid       (pc_valid[0]),
        .misaligned     (misaligned[0]),
        .fault_addr     (fault_addr[0]),
        .update_count   (update_count[0]),
        .state_o        (state_o[0])
    );

    pc_unit #(.ALIGN(2)) u_dut_a2 (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .trap_valid     (trap_valid),
        .halt_req       (halt_req),
        .resume         (resume),
        .curr_addr      (curr_addr[1]),
        .pc_valid       (pc_valid[1]),
        .misaligned     (misaligned[1]),
        .fault_addr     (fault_addr[1]),
        .update_count   (update_count[1]),
        .state_o        (state_o[1])
    );

    // Behavioural model, one slot per instance. States: 0 boot, 1 run, 2 halt, 3 fault.
    int          m_state[2];
    logic [31:0] m_addr [2];
    logic [31:0] m_fault[2];
    logic [31:0] m_count[2];
    bit          model_known = 1'b0;
    int          m_align[2] = '{4, 2};

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_state[i] = 0;
                m_addr[i]  = 32'h0;
                m_fault[i] = 32'h0;
                m_count[i] = 32'h0;
            end else if (m_state[i] == 0) begin
                m_state[i] = 1;
            end else if (m_state[i] == 1) begin
                if (trap_valid) begin
                    m_addr[i] = 32'h100;
                    m_count[i]++;
                end else if (redirect_valid) begin
                    if (redirect_addr % m_align[i] == 0) begin
                        m_addr[i] = redirect_addr;
                        m_count[i]++;
                    end else begin
                        m_fault[i] = redirect_addr;
                        m_state[i] = 3;
                    end
                end else if (halt_req) begin
                    m_state[i] = 2;
                end else if (!stall) begin
                    m_addr[i] = m_addr[i] + 32'd4;
                    m_count[i]++;
                end
            end else if (trap_valid) begin
                m_addr[i]  = 32'h100;
                m_count[i]++;
                m_state[i] = 1;
            end else if (m_state[i] == 2 && resume) begin
                m_state[i] = 1;
            end
        end
        if (rst) model_known = 1'b1;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    initial forever begin
        @(negedge clk);
        if (model_known) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("model.curr_addr[%0d]", i), 64'(curr_addr[i]), 64'(m_addr[i]));
                check($sformatf("model.state[%0d]", i), 64'(state_o[i]), 64'(m_state[i]));
                check($sformatf("model.pc_valid[%0d]", i), 64'(pc_valid[i]),
                      64'(m_state[i] == 1));
                check($sformatf("model.misaligned[%0d]", i), 64'(misaligned[i]),
                      64'(m_state[i] == 3));
                check($sformatf("model.fault_addr[%0d]", i), 64'(fault_addr[i]),
                      64'(m_fault[i]));
                check($sformatf("model.update_count[%0d]", i), 64'(update_count[i]),
                      64'(m_count[i]));
            end
        end
    end

    // Advance one cycle; returns at the following negedge with outputs settled.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic idle_inputs();
        rst = 0; stall = 0; redirect_valid = 0; trap_valid = 0; halt_req = 0; resume = 0;
    endtask

    initial begin
        @(negedge clk);
        // Reset release.
        rst = 1;
        tick(2);
        check("rst.curr_addr", 64'(curr_addr[0]), 64'h0);
        check("rst.state", 64'(state_o[0]), 64'd0);
        check("rst.pc_valid", 64'(pc_valid[0]), 64'd0);
        check("rst.count", 64'(update_count[0]), 64'd0);
        check("rst.fault_addr", 64'(fault_addr[0]), 64'h0);
        rst = 0;
        tick();
        check("boot.state", 64'(state_o[0]), 64'd1);
        check("boot.first_addr", 64'(curr_addr[0]), 64'h0);
        tick(3);
        check("seq.addr", 64'(curr_addr[0]), 64'hC);
        check("seq.count", 64'(update_count[0]), 64'd3);

        // Stall, then redirect overriding stall.
        stall = 1;
        tick(2);
        check("stall.addr", 64'(curr_addr[0]), 64'hC);
        check("stall.count", 64'(update_count[0]), 64'd3);
        redirect_valid = 1; redirect_addr = 32'h20;
        tick();
        check("redir.addr", 64'(curr_addr[0]), 64'h20);
        idle_inputs();
        tick();
        check("redir.next", 64'(curr_addr[0]), 64'h24);
        check("redir.count", 64'(update_count[0]), 64'd5);

        // Misaligned for ALIGN=4, legal for ALIGN=2.
        redirect_valid = 1; redirect_addr = 32'h22;
        tick();
        idle_inputs();
        check("fault.state", 64'(state_o[0]), 64'd3);
        check("fault.misaligned", 64'(misaligned[0]), 64'd1);
        check("fault.pc_valid", 64'(pc_valid[0]), 64'd0);
        check("fault.fault_addr", 64'(fault_addr[0]), 64'h22);
        check("fault.addr_held", 64'(curr_addr[0]), 64'h24);
        check("align2.accept", 64'(curr_addr[1]), 64'h22);
        check("align2.state", 64'(state_o[1]), 64'd1);
        stall = 1; halt_req = 1; redirect_valid = 1; redirect_addr = 32'h80;
        tick();
        check("fault.ignores", 64'(curr_addr[0]), 64'h24);
        idle_inputs();
        trap_valid = 1;
        tick();
        idle_inputs();
        check("trap.addr", 64'(curr_addr[0]), 64'h100);
        check("trap.state", 64'(state_o[0]), 64'd1);
        check("trap.misaligned", 64'(misaligned[0]), 64'd0);
        check("trap.fault_kept", 64'(fault_addr[0]), 64'h22);

        // Halt / resume.
        redirect_valid = 1; redirect_addr = 32'h40;
        tick();
        redirect_valid = 0; halt_req = 1;
        tick();
        halt_req = 0;
        check("halt.state", 64'(state_o[0]), 64'd2);
        check("halt.pc_valid", 64'(pc_valid[0]), 64'd0);
        for (int k = 0; k < 3; k++) begin
            stall = k[0]; redirect_valid = ~k[0]; redirect_addr = 32'h200;
            tick();
        end
        idle_inputs();
        check("halt.held", 64'(curr_addr[0]), 64'h40);
        resume = 1;
        tick();
        resume = 0;
        check("resume.addr", 64'(curr_addr[0]), 64'h40);
        check("resume.state", 64'(state_o[0]), 64'd1);
        tick();
        check("resume.next", 64'(curr_addr[0]), 64'h44);

        // Wrap and trap-over-redirect priority.
        redirect_valid = 1; redirect_addr = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 0;
        tick();
        check("wrap.addr", 64'(curr_addr[0]), 64'h0);
        trap_valid = 1; redirect_valid = 1; redirect_addr = 32'h300;
        tick();
        idle_inputs();
        check("prio.trap", 64'(curr_addr[0]), 64'h100);

        // Reset mid-FAULT.
        redirect_valid = 1; redirect_addr = 32'h3;
        tick();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
        check("rstfault.state", 64'(state_o[0]), 64'd0);
        check("rstfault.addr", 64'(curr_addr[0]), 64'h0);
        check("rstfault.count", 64'(update_count[0]), 64'd0);
        check("rstfault.fault_addr", 64'(fault_addr[0]), 64'h0);

        // Reset mid-HALT.
        tick(3);
        halt_req = 1;
        tick();
        halt_req = 0;
        check("prehalt.state", 64'(state_o[0]), 64'd2);
        rst = 1;
        tick();
        rst = 0;
        check("rsthalt.state", 64'(state_o[0]), 64'd0);
        check("rsthalt.count", 64'(update_count[0]), 64'd0);

        // Randomized phase, checked by the per-cycle model comparison.
        for (int c = 0; c < 3000; c++) begin
            rst            = ($urandom_range(0, 199) == 0);
            trap_valid     = ($urandom_range(0, 19) == 0);
            redirect_valid = ($urandom_range(0, 6) == 0);
            halt_req       = ($urandom_range(0, 11) == 0);
            resume         = ($urandom_range(0, 3) == 0);
            stall          = ($urandom_range(0, 3) == 0);
            redirect_addr  = $urandom;
            if ($urandom_range(0, 3) != 0) redirect_addr[1:0] = 2'b00;
            if ($urandom_range(0, 15) == 0) redirect_addr = 32'hFFFF_FFF0;
            tick();
        end
        idle_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
